// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use interlock, EX redirect
// flushes, data-memory wait freezing, stall-cycle counter and memory timeout pulse.
module hazard_ctrl #(
  parameter logic [1:0]  WD_SEL_MEM  = 2'b01,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id_i,
  input  logic [4:0]       rs2_id_i,
  input  logic             rs1_used_id_i,
  input  logic             rs2_used_id_i,
  input  logic [4:0]       wr_ex_i,
  input  logic             rf_we_ex_i,
  input  logic [1:0]       wd_sel_ex_i,
  input  logic             instr_valid_ex_i,
  input  logic             redirect_ex_i,
  input  logic             dmem_req_mem_i,
  input  logic             dmem_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             flush_wb_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] perf_stall_cnt_o
);

  localparam int unsigned     WC_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_ERR = WC_W'(MEM_TIMEOUT - 2);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [WC_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic              err_timeout_r, err_set_s;
  logic [CNT_W-1:0]  perf_cnt_r;
  logic              mem_wait_s, load_use_s;
  logic              stall_if_s, stall_id_s, stall_ex_s, stall_mem_s;
  logic              flush_id_s, flush_ex_s, flush_wb_s;

  function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] wr);
    return used && (rs == wr);
  endfunction

  assign load_use_s = instr_valid_ex_i && rf_we_ex_i && (wd_sel_ex_i == WD_SEL_MEM) &&
                      (wr_ex_i != 5'd0) &&
                      (src_hit(rs1_used_id_i, rs1_id_i, wr_ex_i) ||
                       src_hit(rs2_used_id_i, rs2_id_i, wr_ex_i));

  // Next state, wait counter and stall/flush decode in priority order
  always_comb begin
    mem_wait_s     = 1'b0;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = {WC_W{1'b0}};
    err_set_s      = 1'b0;
    stall_if_s     = 1'b0;
    stall_id_s     = 1'b0;
    stall_ex_s     = 1'b0;
    stall_mem_s    = 1'b0;
    flush_id_s     = 1'b0;
    flush_ex_s     = 1'b0;
    flush_wb_s     = 1'b0;

    // Once waiting, only ready matters; the ready cycle itself behaves as RUN
    case (state_r)
      RUN: begin
        mem_wait_s = dmem_req_mem_i && !dmem_ready_i;
      end
      MEM_WAIT: begin
        mem_wait_s = !dmem_ready_i;
        if (mem_wait_s) begin
          wait_cnt_nxt_s = (wait_cnt_r == WC_MAX) ? WC_MAX : wait_cnt_r + {{(WC_W-1){1'b0}}, 1'b1};
          err_set_s      = (wait_cnt_r == WC_ERR);
        end else begin
          wait_cnt_nxt_s = {WC_W{1'b0}};
        end
      end
      default: begin
        mem_wait_s = 1'b0;
      end
    endcase

    state_nxt_s = mem_wait_s ? MEM_WAIT : RUN;

    if (mem_wait_s) begin
      stall_if_s  = 1'b1;
      stall_id_s  = 1'b1;
      stall_ex_s  = 1'b1;
      stall_mem_s = 1'b1;
      flush_wb_s  = 1'b1;
    end else if (redirect_ex_i) begin
      flush_id_s  = 1'b1;
      flush_ex_s  = 1'b1;
    end else if (load_use_s) begin
      stall_if_s  = 1'b1;
      stall_id_s  = 1'b1;
      flush_ex_s  = 1'b1;
    end else begin
      stall_if_s  = 1'b0;
    end
  end

  // State, wait counter, timeout pulse and stall-cycle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RUN;
      wait_cnt_r    <= {WC_W{1'b0}};
      err_timeout_r <= 1'b0;
      perf_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      err_timeout_r <= err_set_s;
      if (stall_if_s) begin
        perf_cnt_r <= perf_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        perf_cnt_r <= perf_cnt_r;
      end
    end
  end

  // Combinational controls are forced low while reset is asserted
  assign stall_if_o       = stall_if_s  && rst_n;
  assign stall_id_o       = stall_id_s  && rst_n;
  assign stall_ex_o       = stall_ex_s  && rst_n;
  assign stall_mem_o      = stall_mem_s && rst_n;
  assign flush_id_o       = flush_id_s  && rst_n;
  assign flush_ex_o       = flush_ex_s  && rst_n;
  assign flush_wb_o       = flush_wb_s  && rst_n;
  assign err_timeout_o    = err_timeout_r;
  assign perf_stall_cnt_o = perf_cnt_r;

endmodule
